// File: rtl/key_event_decoder.sv
// Two-key click decoder: synchronizes active-low key levels and classifies each press
// as a short click, a double click or a long press, using a shared 1 ms prescaler.
module key_event_decoder #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_n,
  output logic [1:0] short_evt,
  output logic [1:0] long_evt,
  output logic [1:0] dbl_evt,
  output logic [1:0] held
);

  localparam int PRE_MAX = CLK_HZ / 1000 - 1;
  localparam int PRE_W   = (PRE_MAX < 2) ? 1 : $clog2(PRE_MAX + 1);
  localparam logic [PRE_W-1:0] PRE_TC    = PRE_W'(PRE_MAX);
  localparam logic [16:0]      LONG_TC   = 17'(LONG_MS);
  localparam logic [16:0]      DCLICK_TC = 17'(DCLICK_MS);
  localparam logic [15:0]      CNT_SAT   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD,
    S_WAIT2,
    S_PRESSED2
  } state_e;

  logic [1:0] sync1_q;
  logic [1:0] ks_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order; the synchronizer resets to
  // "released" so a reset never manufactures a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      ks_q    <= 2'b11;
    end else begin
      sync1_q <= key_n;
      ks_q    <= sync1_q;
    end
  end

  logic [PRE_W-1:0] pre_q;
  logic             tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (pre_q == PRE_TC) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign tick = (pre_q == PRE_TC);

  for (genvar k = 0; k < 2; k++) begin : g_key
    state_e      state_q;
    logic [15:0] cnt_q;
    logic [16:0] cnt_inc;
    logic        short_q;
    logic        long_q;
    logic        dbl_q;
    logic        held_q;

    // Threshold compare is done one count ahead so the event lands on the tick itself.
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    // A key-level change is tested before the tick in every state, so a release or
    // press landing on a threshold tick always wins.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        dbl_q   <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        short_q <= 1'b0;
        long_q  <= 1'b0;
        dbl_q   <= 1'b0;
        if (tick && cnt_q != CNT_SAT) begin
          cnt_q <= cnt_q + 16'd1;
        end
        case (state_q)
          S_IDLE: begin
            if (!ks_q[k]) begin
              state_q <= S_PRESSED;
              cnt_q   <= '0;
            end
          end
          S_PRESSED: begin
            if (ks_q[k]) begin
              state_q <= S_WAIT2;
              cnt_q   <= '0;
            end else if (tick && cnt_inc == LONG_TC) begin
              state_q <= S_LONG_HELD;
              cnt_q   <= '0;
              long_q  <= 1'b1;
              held_q  <= 1'b1;
            end
          end
          S_LONG_HELD: begin
            if (ks_q[k]) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              held_q  <= 1'b0;
            end
          end
          S_WAIT2: begin
            if (!ks_q[k]) begin
              state_q <= S_PRESSED2;
              cnt_q   <= '0;
            end else if (tick && cnt_inc == DCLICK_TC) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              short_q <= 1'b1;
            end
          end
          S_PRESSED2: begin
            if (ks_q[k]) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              dbl_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end

    assign short_evt[k] = short_q;
    assign long_evt[k]  = long_q;
    assign dbl_evt[k]   = dbl_q;
    assign held[k]      = held_q;
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: a duration-based reference model predicts
// each event and its cycle; a negedge monitor pops and compares what the DUT emits.
module tb_key_event_decoder;

  localparam int CLK_HZ    = 10_000;
  localparam int LONG_MS   = 20;
  localparam int DCLICK_MS = 5;
  localparam int PRE_N     = CLK_HZ / 1000;
  localparam int EV_SHORT  = 0;
  localparam int EV_LONG   = 1;
  localparam int EV_DBL    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_n = 2'b11;
  logic [1:0] short_evt, long_evt, dbl_evt, held;

  key_event_decoder #(
    .CLK_HZ   (CLK_HZ),
    .LONG_MS  (LONG_MS),
    .DCLICK_MS(DCLICK_MS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .short_evt(short_evt),
    .long_evt (long_evt),
    .dbl_evt  (dbl_evt),
    .held     (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  exp_t exp_q[2][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   evt_cnt[2][3];
  int   last_evt[2][3];
  int   held_rise[2];
  int   held_fall[2];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      for (int e = 0; e < 3; e++) begin
        evt_cnt[k][e]  = 0;
        last_evt[k][e] = -1;
      end
      held_rise[k] = -1;
      held_fall[k] = -1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Reference model: tracks whether each key is down, how many ms have elapsed since
  // its last level change, and what the previous click left pending.
  bit [1:0] m_s1, m_s2, lvl, waiting, second, long_fired, m_held;
  int       m_pre;
  int       ms[2];

  initial forever begin
    bit       tk;
    bit [1:0] ks_old;
    int       ev;
    exp_t     e;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = 2'b11; m_s2 = 2'b11; lvl = 2'b11;
      waiting = '0; second = '0; long_fired = '0; m_held = '0;
      m_pre = 0; ms[0] = 0; ms[1] = 0;
    end else begin
      tk     = (m_pre == PRE_N - 1);
      ks_old = m_s2;
      for (int k = 0; k < 2; k++) begin
        ev = -1;
        if (ks_old[k] != lvl[k]) begin
          if (lvl[k]) begin
            second[k]     = waiting[k];
            waiting[k]    = 1'b0;
            long_fired[k] = 1'b0;
          end else begin
            if (long_fired[k]) m_held[k] = 1'b0;
            else if (second[k]) ev = EV_DBL;
            else waiting[k] = 1'b1;
            second[k] = 1'b0;
          end
          lvl[k] = ks_old[k];
          ms[k]  = 0;
        end else if (tk) begin
          if (!lvl[k] && !second[k] && !long_fired[k] && ms[k] + 1 == LONG_MS) begin
            ev = EV_LONG; long_fired[k] = 1'b1; m_held[k] = 1'b1; ms[k] = 0;
          end else if (lvl[k] && waiting[k] && ms[k] + 1 == DCLICK_MS) begin
            ev = EV_SHORT; waiting[k] = 1'b0; ms[k] = 0;
          end else if (ms[k] < 65535) begin
            ms[k]++;
          end
        end
        if (ev >= 0) begin
          e.cyc  = cyc + 1;
          e.kind = ev;
          exp_q[k].push_back(e);
        end
      end
      m_s2  = m_s1;
      m_s1  = key_n;
      m_pre = (m_pre == PRE_N - 1) ? 0 : m_pre + 1;
    end
  end

  bit [1:0] prev_held = '0;

  initial forever begin
    logic [2:0] bits;
    int         kind;
    exp_t       e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bits = {dbl_evt[k], long_evt[k], short_evt[k]};
      if (bits != 3'b000) begin
        check($sformatf("onehot_key%0d", k), $countones(bits), 1);
        kind = bits[0] ? EV_SHORT : (bits[1] ? EV_LONG : EV_DBL);
        evt_cnt[k][kind]++;
        last_evt[k][kind] = cyc;
        check($sformatf("evt_expected_key%0d", k), (exp_q[k].size() > 0) ? 1 : 0, 1);
        if (exp_q[k].size() > 0) begin
          e = exp_q[k].pop_front();
          check($sformatf("evt_kind_key%0d", k), kind, e.kind);
          check($sformatf("evt_cycle_key%0d", k), cyc, e.cyc);
        end
      end else begin
        while (exp_q[k].size() > 0 && exp_q[k][0].cyc <= cyc) begin
          e = exp_q[k].pop_front();
          check($sformatf("evt_missed_key%0d", k), -1, e.kind);
        end
      end
      check($sformatf("held_key%0d", k), int'(held[k]), int'(m_held[k]));
      if (held[k] && !prev_held[k]) held_rise[k] = cyc;
      if (!held[k] && prev_held[k]) held_fall[k] = cyc;
      prev_held[k] = held[k];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1, "bench timed out");
  end

  initial begin
    int r, p, r0, rr, n;
    clear_stats();
    rst_n = 1'b0;
    key_n = 2'b11;
    repeat (3) begin
      step();
      check("reset_outputs", int'({short_evt, long_evt, dbl_evt, held}), 0);
    end
    rst_n = 1'b1;
    repeat (20) step();

    // Short click on key 0.
    clear_stats();
    key_n[0] = 1'b0;
    repeat (50) step();
    key_n[0] = 1'b1;
    r = cyc;
    repeat (100) step();
    check("short_click_short_cnt", evt_cnt[0][EV_SHORT], 1);
    check("short_click_long_cnt", evt_cnt[0][EV_LONG], 0);
    check("short_click_dbl_cnt", evt_cnt[0][EV_DBL], 0);
    check_range("short_click_delay", last_evt[0][EV_SHORT] - r, 40, 60);

    // Long press on key 1.
    clear_stats();
    key_n[1] = 1'b0;
    p = cyc;
    repeat (300) step();
    key_n[1] = 1'b1;
    r = cyc;
    repeat (80) step();
    check("long_press_long_cnt", evt_cnt[1][EV_LONG], 1);
    check("long_press_short_cnt", evt_cnt[1][EV_SHORT], 0);
    check_range("long_press_delay", last_evt[1][EV_LONG] - p, 190, 210);
    check_range("held_rise_delay", held_rise[1] - p, 190, 210);
    check("held_fall_delay", held_fall[1] - r, 3);

    // Double click on key 0.
    clear_stats();
    key_n[0] = 1'b0; repeat (30) step();
    key_n[0] = 1'b1; repeat (20) step();
    key_n[0] = 1'b0; repeat (30) step();
    key_n[0] = 1'b1;
    r = cyc;
    repeat (100) step();
    check("dbl_click_dbl_cnt", evt_cnt[0][EV_DBL], 1);
    check("dbl_click_short_cnt", evt_cnt[0][EV_SHORT], 0);
    check("dbl_click_delay", last_evt[0][EV_DBL] - r, 3);

    // Concurrent short click on key 0 and long press on key 1.
    clear_stats();
    key_n = 2'b00;
    p = cyc;
    repeat (50) step();
    key_n[0] = 1'b1;
    r0 = cyc;
    repeat (250) step();
    key_n[1] = 1'b1;
    repeat (100) step();
    check_range("concurrent_short_delay", last_evt[0][EV_SHORT] - r0, 40, 60);
    check_range("concurrent_long_delay", last_evt[1][EV_LONG] - p, 190, 210);
    check("concurrent_short_cnt", evt_cnt[0][EV_SHORT], 1);
    check("concurrent_long_cnt", evt_cnt[1][EV_LONG], 1);

    // Reset while key 0 is pressed; the still-held key becomes a new press.
    clear_stats();
    key_n[0] = 1'b0;
    repeat (50) step();
    rst_n = 1'b0;
    repeat (5) begin
      step();
      check("mid_reset_outputs", int'({short_evt, long_evt, dbl_evt, held}), 0);
    end
    rst_n = 1'b1;
    rr = cyc;
    repeat (260) step();
    check("post_reset_long_cnt", evt_cnt[0][EV_LONG], 1);
    check_range("post_reset_long_delay", last_evt[0][EV_LONG] - rr, 190, 210);
    key_n[0] = 1'b1;
    repeat (30) step();

    // Synchronized release lands on the tick that would reach the long threshold.
    clear_stats();
    key_n[0] = 1'b0;
    n = 0;
    while (!(lvl[0] == 1'b0 && ms[0] == LONG_MS - 1 && m_pre == PRE_N - 3) && n < 400) begin
      step();
      n++;
    end
    check("release_on_tick_aligned", (n < 400) ? 1 : 0, 1);
    key_n[0] = 1'b1;
    repeat (100) step();
    check("release_on_tick_long_cnt", evt_cnt[0][EV_LONG], 0);
    check("release_on_tick_short_cnt", evt_cnt[0][EV_SHORT], 1);

    // Randomized activity on both keys.
    for (int i = 0; i < 60; i++) begin
      key_n = 2'($urandom);
      repeat ($urandom_range(1, 240)) step();
    end
    key_n = 2'b11;
    repeat (300) step();
    check("pending_key0_at_end", exp_q[0].size(), 0);
    check("pending_key1_at_end", exp_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, clk frequency in Hz; CLK_HZ/1000 SHALL be an integer of at least 2.
REQ-002 Parameter LONG_MS, 1000, long-press threshold in ms; range 1..65535.
REQ-003 Parameter DCLICK_MS, 300, window after a release in which a second press counts as a double click; range 1..65535.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 key_n  input  2  debounced key levels, active-low (0 = pressed); may be asynchronous to clk.
REQ-007 short_evt  output  2  one-cycle pulse per key: single short click.
REQ-008 long_evt  output  2  one-cycle pulse per key: long-press threshold reached.
REQ-009 dbl_evt  output  2  one-cycle pulse per key: double click.
REQ-010 held  output  2  level per key: high while a long press is in progress.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchronizer (reset value 1 = released); the FSM sees only the synchronized level ks.
REQ-012 A shared prescaler SHALL count 0..CLK_HZ/1000-1 and wrap; tick SHALL pulse for one clk on the terminal count (every 1 ms).
REQ-013 Each key SHALL have an independent FSM {IDLE, PRESSED, LONG_HELD, WAIT2, PRESSED2} and a 16-bit ms counter cnt that increments on tick, saturates at 65535 and clears to 0 on every state change.
REQ-014 IDLE: ks=0 -> PRESSED.
REQ-015 PRESSED: ks=1 -> WAIT2; else tick with cnt+1==LONG_MS -> LONG_HELD, pulse long_evt, set held.
REQ-016 LONG_HELD: ks=1 -> IDLE, clear held; no short_evt or dbl_evt is generated for this press.
REQ-017 WAIT2: ks=0 -> PRESSED2; else tick with cnt+1==DCLICK_MS -> IDLE, pulse short_evt.
REQ-018 PRESSED2: ks=1 -> IDLE, pulse dbl_evt; hold duration is irrelevant (no long_evt, held stays 0).
REQ-019 Events SHALL be registered, high for exactly one clk, and asserted in the cycle the FSM enters the destination state (3 clk edges after the causing key_n edge, or 1 edge after the causing tick).
REQ-020 Simultaneous events: a level change on ks SHALL take priority over a coincident threshold tick (release wins in PRESSED, press wins in WAIT2).
REQ-021 At most one of short_evt/long_evt/dbl_evt SHALL be high per key per cycle; the two keys SHALL be fully independent and may pulse in the same cycle.
REQ-022 The prescaler free-runs and is not aligned to key edges, so measured durations SHALL have a resolution of -1/+0 ms.

Reset
REQ-023 While rst_n=0, all outputs SHALL be 0, all FSMs IDLE, cnt and prescaler 0, and synchronizers 1, regardless of clk.
REQ-024 Reset mid-operation SHALL abandon any pending event; a key still held at reset release SHALL be treated as a new press 2 clk later.

Verification (CLK_HZ=10_000 i.e. tick every 10 clk, LONG_MS=20, DCLICK_MS=5)
REQ-025 key_n[0] low 50 clk, then high -> exactly one short_evt[0] pulse 50 clk (+/-10) after release; no long_evt or dbl_evt.
REQ-026 key_n[1] low 300 clk -> long_evt[1] pulse and held[1] rising 200 clk (+/-10) after press; held[1] falls 3 clk after release; no short_evt.
REQ-027 key_n[0] low 30, high 20, low 30, then high -> dbl_evt[0] exactly 3 clk after the second release; no short_evt[0].
REQ-028 key 0 short click concurrent with key 1 long press -> short_evt[0] and long_evt[1] with the same timing as in REQ-025 and REQ-026 respectively.
REQ-029 rst_n low for 5 clk while key_n[0] is in PRESSED -> all outputs 0 during reset; key still held afterward -> new press, long_evt[0] 200 clk (+/-10) after reset release.
REQ-030 Force the synchronized release onto the same cycle as the tick that would reach LONG_MS -> no long_evt; a short_evt follows after DCLICK_MS.
